pipeline_skid_reg: RTL and testbench



---
 rtl/pipeline_skid_reg_if.sv | 12 +
 rtl/pipeline_skid_reg.sv | 101 ++++++++++
 tb/tb_pipeline_skid_reg.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pipeline_skid_reg_if.sv
// Valid/ready handshake bundle for one side of a pipeline stage.
// master drives valid/data, slave drives ready.
interface pipeline_skid_reg_if #(
    parameter int WIDTH = 64
);
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipeline_skid_reg.sv
// Elastic pipeline stage: two-entry skid buffer with a registered in_ready,
// synchronous flush-to-bubble, and a saturating stall counter.
module pipeline_skid_reg #(
    parameter int               WIDTH  = 64,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter int               CNT_W  = 16
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                flush,
    pipeline_skid_reg_if.slave  in_if,
    pipeline_skid_reg_if.master out_if,
    output logic [CNT_W-1:0]    stall_cnt
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   main_q, main_d;
    logic [WIDTH-1:0]   skid_q, skid_d;
    logic               in_ready_q, in_ready_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic               out_valid;
    logic               in_fire, out_fire;

    assign out_valid    = (state_q != EMPTY);
    assign out_if.valid = out_valid;
    assign out_if.data  = main_q;
    assign in_if.ready  = in_ready_q;
    assign stall_cnt    = stall_q;

    assign in_fire  = in_if.valid & in_ready_q;
    assign out_fire = out_valid & out_if.ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // A same-cycle in_fire is dropped; out_fire already happened downstream.
            state_d = EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_if.data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_if.data;
                    end else if (in_fire) begin
                        skid_d  = in_if.data;
                        state_d = TWO;
                    end else if (out_fire) begin
                        main_d  = BUBBLE;
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        skid_d  = BUBBLE;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end
        // Ready is a function of the next state only, so out_ready never reaches it combinationally.
        in_ready_d = (state_d != TWO);

        stall_d = stall_q;
        if (out_valid && !out_if.ready && (stall_q != {CNT_W{1'b1}}))
            stall_d = stall_q + CNT_W'(1);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= EMPTY;
            main_q     <= BUBBLE;
            skid_q     <= BUBBLE;
            in_ready_q <= 1'b1;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
            stall_q    <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipeline_skid_reg.sv
// Directed checks on a narrow instance (CNT_W=4) plus a FIFO-scoreboarded
// random run on a 168-bit instance with a non-zero bubble.
module tb_pipeline_skid_reg;

    localparam logic [167:0] BUB = {{10{16'hDEAD}}, 8'hBE};

    logic CLK;
    logic nRST;
    logic a_flush, b_flush;
    logic [3:0]  a_stall;
    logic [15:0] b_stall;

    int checks = 0;
    int errors = 0;

    pipeline_skid_reg_if #(.WIDTH(64))  a_in ();
    pipeline_skid_reg_if #(.WIDTH(64))  a_out ();
    pipeline_skid_reg_if #(.WIDTH(168)) b_in ();
    pipeline_skid_reg_if #(.WIDTH(168)) b_out ();

    pipeline_skid_reg #(.WIDTH(64), .BUBBLE(64'h0), .CNT_W(4)) dut_a (
        .CLK(CLK), .nRST(nRST), .flush(a_flush),
        .in_if(a_in), .out_if(a_out), .stall_cnt(a_stall)
    );

    pipeline_skid_reg #(.WIDTH(168), .BUBBLE(BUB), .CNT_W(16)) dut_b (
        .CLK(CLK), .nRST(nRST), .flush(b_flush),
        .in_if(b_in), .out_if(b_out), .stall_cnt(b_stall)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [167:0] obs, input logic [167:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic a_state(input string tag, input logic v, input logic [63:0] d, input logic rdy);
        chk({tag, "_valid"}, 168'(a_out.valid), 168'(v));
        chk({tag, "_data"},  168'(a_out.data),  168'(d));
        chk({tag, "_ready"}, 168'(a_in.ready),  168'(rdy));
    endtask

    logic [167:0] q[$];
    logic [191:0] rnd;
    logic         v, r, f, m_in_fire, m_out_fire;

    initial begin
        nRST = 1'b0;
        a_flush = 1'b0; b_flush = 1'b0;
        a_in.valid = 1'b0; a_in.data = '0; a_out.ready = 1'b0;
        b_in.valid = 1'b0; b_in.data = '0; b_out.ready = 1'b0;
        #12;
        a_state("rst", 1'b0, 64'h0, 1'b1);
        chk("rst_stall", 168'(a_stall), 168'(0));
        chk("b_rst_data", b_out.data, BUB);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK); #1;

        // Back-to-back streaming with the sink always ready
        a_out.ready = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            a_in.valid = 1'b1;
            a_in.data  = 64'(i);
            step();
            a_state("stream", 1'b1, 64'(i), 1'b1);
        end
        a_in.valid = 1'b0;
        step();
        a_state("drain", 1'b0, 64'h0, 1'b1);
        chk("stream_stall", 168'(a_stall), 168'(0));

        // Backpressure: third word must wait upstream
        a_out.ready = 1'b0;
        a_in.valid = 1'b1; a_in.data = 64'h10;
        step();
        a_state("bp1", 1'b1, 64'h10, 1'b1);
        a_in.data = 64'h11;
        step();
        a_state("bp2", 1'b1, 64'h10, 1'b0);
        a_in.data = 64'h12;
        step();
        a_state("bp3", 1'b1, 64'h10, 1'b0);
        a_out.ready = 1'b1;
        step();
        a_state("rec1", 1'b1, 64'h11, 1'b1);
        step();
        a_state("rec2", 1'b1, 64'h12, 1'b1);
        a_in.valid = 1'b0;
        step();
        a_state("rec3", 1'b0, 64'h0, 1'b1);
        chk("bp_stall", 168'(a_stall), 168'(2));

        // Flush while full with 0x55 offered, then flush against a real in_fire of 0x56
        a_out.ready = 1'b0;
        a_in.valid = 1'b1; a_in.data = 64'h20;
        step();
        a_in.data = 64'h21;
        step();
        a_state("full", 1'b1, 64'h20, 1'b0);
        a_in.data = 64'h55; a_flush = 1'b1;
        step();
        a_state("flush2", 1'b0, 64'h0, 1'b1);
        a_in.data = 64'h56;
        step();
        a_state("flush_fire", 1'b0, 64'h0, 1'b1);
        a_flush = 1'b0; a_in.valid = 1'b0;
        step();
        a_state("post_flush", 1'b0, 64'h0, 1'b1);
        a_out.ready = 1'b1;
        a_in.valid = 1'b1; a_in.data = 64'h77;
        step();
        a_state("after_flush", 1'b1, 64'h77, 1'b1);
        a_in.valid = 1'b0;
        step();

        // Asynchronous reset mid-cycle with two entries held
        a_out.ready = 1'b0;
        a_in.valid = 1'b1; a_in.data = 64'h30;
        step();
        a_in.data = 64'h31;
        step();
        a_state("pre_rst", 1'b1, 64'h30, 1'b0);
        a_in.valid = 1'b0;
        #2 nRST = 1'b0;
        #1;
        a_state("mid_rst", 1'b0, 64'h0, 1'b1);
        chk("mid_rst_stall", 168'(a_stall), 168'(0));
        #1 nRST = 1'b1;
        @(posedge CLK); #1;
        a_in.valid = 1'b1; a_in.data = 64'hA5;
        step();
        a_state("first_push", 1'b1, 64'hA5, 1'b1);
        a_in.valid = 1'b0;

        // Stall counter: exact counting, then saturation at 15, then immunity to flush
        for (int i = 0; i < 5; i++) step();
        chk("stall5", 168'(a_stall), 168'(5));
        for (int i = 0; i < 15; i++) step();
        chk("stall_sat", 168'(a_stall), 168'(15));
        a_state("sat_hold", 1'b1, 64'hA5, 1'b1);
        a_flush = 1'b1;
        step();
        a_flush = 1'b0;
        chk("sat_flush", 168'(a_stall), 168'(15));
        a_state("sat_flushed", 1'b0, 64'h0, 1'b1);

        // Wide instance: random traffic against a reference FIFO
        chk("b_empty_data", b_out.data, BUB);
        for (int c = 0; c < 400; c++) begin
            chk("b_valid", 168'(b_out.valid), 168'(q.size() != 0));
            chk("b_data", b_out.data, (q.size() != 0) ? q[0] : BUB);
            chk("b_ready", 168'(b_in.ready), 168'(q.size() < 2));
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            f = ($urandom_range(0, 31) == 0);
            for (int k = 0; k < 6; k++) rnd[k*32 +: 32] = $urandom();
            b_in.valid = v; b_in.data = rnd[167:0];
            b_out.ready = r; b_flush = f;
            m_in_fire  = v && (q.size() < 2);
            m_out_fire = r && (q.size() != 0);
            if (f) begin
                q.delete();
            end else begin
                if (m_out_fire) void'(q.pop_front());
                if (m_in_fire) q.push_back(rnd[167:0]);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
